// File: rtl/item_note_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// piezo_pkg
// Definitions shared by the note sequencer, the piezo tone generator and the
// vending FSM:
//   - melody ids MEL_NONE (0) and MEL_100W (1) through MEL_PROD3 (6)
//   - NUM_NOTES, the number of notes in every melody
//   - 2-bit sequencer state encoding (IDLE / PLAY / GAP)
//   - ev_winner(): highest-index arbitration over the event strobes
// ---------------------------------------------------------------------------
package piezo_pkg;

  typedef logic [2:0] mel_id_t;
  typedef logic [5:0] ev_vec_t;

  localparam mel_id_t MEL_NONE  = 3'd0;
  localparam mel_id_t MEL_100W  = 3'd1;
  localparam mel_id_t MEL_500W  = 3'd2;
  localparam mel_id_t MEL_1000W = 3'd3;
  localparam mel_id_t MEL_PROD1 = 3'd4;
  localparam mel_id_t MEL_PROD2 = 3'd5;
  localparam mel_id_t MEL_PROD3 = 3'd6;

  localparam int NUM_NOTES = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Highest set strobe wins, so product melodies beat coin melodies.
  function automatic mel_id_t ev_winner(input ev_vec_t ev);
    mel_id_t w;
    w = MEL_NONE;
    for (int i = 0; i < 6; i++) begin
      if (ev[i]) begin
        w = mel_id_t'(i + 1);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/item_note_sequencer_if.sv
// ---------------------------------------------------------------------------
// item_note_sequencer_if
// Bundle between the vending FSM, the note sequencer and the tone generator.
//   ev          : one-cycle event strobes, ev[i-1] requests melody id i
//   abort       : synchronous stop request
//   note_state  : melody id being played, 0 when idle
//   note_played : note index 1..4 while sounding, 0 in gaps and idle
//   busy        : melody in progress
//   done        : one-cycle pulse on normal completion
// Modports:
//   master : the sequencer (consumes ev/abort, drives the note signals)
//   slave  : the environment (drives ev/abort, observes the note signals)
// ---------------------------------------------------------------------------
interface item_note_sequencer_if;
  import piezo_pkg::*;

  ev_vec_t ev;
  logic    abort;
  mel_id_t note_state;
  logic [2:0] note_played;
  logic    busy;
  logic    done;

  modport master (
    input  ev,
    input  abort,
    output note_state,
    output note_played,
    output busy,
    output done
  );

  modport slave (
    output ev,
    output abort,
    input  note_state,
    input  note_played,
    input  busy,
    input  done
  );

endinterface

// File: rtl/item_note_sequencer_timer.sv
// ---------------------------------------------------------------------------
// note_timer
// Loadable down-counter used for both note and gap durations.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : stop and zero the counter (wins over load)
//   load      : start a new interval lasting load_val+1 cycles
//   load_val  : interval length minus one
//   expire    : high in the final cycle of the running interval
//   zero_next : the counter will sit in its final cycle next clock; lets the
//               parent register an output that lines up with expire
// ---------------------------------------------------------------------------
module note_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire,
  output logic         zero_next
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  // Next count: clear, reload, or count down and stop once the final cycle passes.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (load) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - ONE;
      end else begin
        run_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire    = run_q && (cnt_q == '0);
  assign zero_next = run_d && (cnt_d == '0);

endmodule

// File: rtl/item_note_sequencer.sv
// ---------------------------------------------------------------------------
// item_note_sequencer
// Turns one-cycle vending events into a timed 4-note melody for the piezo
// tone generator: note 1, gap, note 2, gap, ... note 4, gap, then done.
// Parameters:
//   NOTE_CYCLES : cycles each note sounds (1 .. 2^24-1)
//   GAP_CYCLES  : silent cycles after each note (0 removes the gap states)
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : item_note_sequencer_if.master (ev, abort in; note_state,
//          note_played, busy, done out -- all outputs registered)
// Build option:
//   PIEZO_QUEUE_EN : when defined, a one-entry pending slot keeps the latest
//                    request seen while busy and starts it on completion.
//                    Undefined, requests while busy are dropped.
// ---------------------------------------------------------------------------
module item_note_sequencer
  import piezo_pkg::*;
#(
  parameter int NOTE_CYCLES = 250000,
  parameter int GAP_CYCLES  = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  item_note_sequencer_if.master bus
);

  localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_NOTE = 3'(NUM_NOTES);
  // The melody ends in its last gap, or in its last note when there are no gaps.
  localparam logic [1:0]       FINAL_ST  = (GAP_CYCLES > 0) ? ST_GAP : ST_PLAY;

  logic [1:0] state_q, state_d;
  logic [2:0] n_q, n_d;
  mel_id_t    note_state_q, note_state_d;
  logic [2:0] note_played_q, note_played_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       complete_s;

  logic             tmr_clear_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_load_val_s;
  logic             tmr_expire_s;
  logic             tmr_zero_next_s;

`ifdef PIEZO_QUEUE_EN
  mel_id_t pend_id_q, pend_id_d;
  logic    pend_v_q, pend_v_d;
`endif

  note_timer #(.W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmr_clear_s),
    .load      (tmr_load_s),
    .load_val  (tmr_load_val_s),
    .expire    (tmr_expire_s),
    .zero_next (tmr_zero_next_s)
  );

  // Sequencing: state, note index, melody id, pending slot and timer control.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    note_state_d   = note_state_q;
    complete_s     = 1'b0;
    tmr_clear_s    = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = NOTE_LOAD;
`ifdef PIEZO_QUEUE_EN
    pend_id_d      = pend_id_q;
    pend_v_d       = pend_v_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.ev != 6'd0) begin
          state_d      = ST_PLAY;
          n_d          = 3'd1;
          note_state_d = ev_winner(bus.ev);
          tmr_load_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (tmr_expire_s) begin
          if (GAP_CYCLES > 0) begin
            state_d        = ST_GAP;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = GAP_LOAD;
          end else if (n_q == LAST_NOTE) begin
            complete_s = 1'b1;
          end else begin
            n_d        = n_q + 3'd1;
            tmr_load_s = 1'b1;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (tmr_expire_s) begin
          if (n_q == LAST_NOTE) begin
            complete_s = 1'b1;
          end else begin
            state_d    = ST_PLAY;
            n_d        = n_q + 3'd1;
            tmr_load_s = 1'b1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        n_d          = 3'd0;
        note_state_d = MEL_NONE;
        tmr_clear_s  = 1'b1;
      end
    endcase

`ifdef PIEZO_QUEUE_EN
    // Requests while busy overwrite the pending slot (latest wins).
    if ((state_q != ST_IDLE) && !complete_s && (bus.ev != 6'd0)) begin
      pend_id_d = ev_winner(bus.ev);
      pend_v_d  = 1'b1;
    end else begin
      pend_v_d = pend_v_d;
    end
`endif

    if (complete_s) begin
`ifdef PIEZO_QUEUE_EN
      // A strobe in the completion cycle beats the stored request.
      if ((bus.ev != 6'd0) || pend_v_q) begin
        state_d      = ST_PLAY;
        n_d          = 3'd1;
        note_state_d = (bus.ev != 6'd0) ? ev_winner(bus.ev) : pend_id_q;
        tmr_load_s   = 1'b1;
      end else begin
        state_d      = ST_IDLE;
        n_d          = 3'd0;
        note_state_d = MEL_NONE;
        tmr_clear_s  = 1'b1;
      end
      pend_v_d  = 1'b0;
      pend_id_d = MEL_NONE;
`else
      state_d      = ST_IDLE;
      n_d          = 3'd0;
      note_state_d = MEL_NONE;
      tmr_clear_s  = 1'b1;
`endif
    end else begin
      complete_s = 1'b0;
    end

    // abort outranks both a new request and completion.
    if (bus.abort) begin
      state_d      = ST_IDLE;
      n_d          = 3'd0;
      note_state_d = MEL_NONE;
      tmr_clear_s  = 1'b1;
      tmr_load_s   = 1'b0;
`ifdef PIEZO_QUEUE_EN
      pend_v_d     = 1'b0;
      pend_id_d    = MEL_NONE;
`endif
    end else begin
      tmr_clear_s = tmr_clear_s;
    end

    note_played_d = (state_d == ST_PLAY) ? n_d : 3'd0;
    busy_d        = (state_d != ST_IDLE);
  end

  // done lands in the last cycle of the melody: the timer's look-ahead tells
  // us the next cycle is the final one of the last note's closing phase.
  always_comb begin
    if ((state_d == FINAL_ST) && (n_d == LAST_NOTE) && tmr_zero_next_s) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      n_q           <= 3'd0;
      note_state_q  <= MEL_NONE;
      note_played_q <= 3'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      note_state_q  <= note_state_d;
      note_played_q <= note_played_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef PIEZO_QUEUE_EN
  // Pending request slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_id_q <= MEL_NONE;
      pend_v_q  <= 1'b0;
    end else begin
      pend_id_q <= pend_id_d;
      pend_v_q  <= pend_v_d;
    end
  end
`endif

  assign bus.note_state  = note_state_q;
  assign bus.note_played = note_played_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_item_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_item_note_sequencer
// Directed bench for item_note_sequencer. Two instances share clk/rst and
// the ev/abort stimulus: dut_a with NOTE_CYCLES=10, GAP_CYCLES=2 and dut_b
// with NOTE_CYCLES=10, GAP_CYCLES=0. "Cycle k" is the interval after the k-th
// clock edge following the strobe; outputs are sampled 1 ns after the edge.
// Expectations follow PIEZO_QUEUE_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_item_note_sequencer;
  import piezo_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  item_note_sequencer_if ifa ();
  item_note_sequencer_if ifb ();

  item_note_sequencer #(.NOTE_CYCLES(10), .GAP_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  item_note_sequencer #(.NOTE_CYCLES(10), .GAP_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] ev, input logic abort);
    ifa.ev    = ev;
    ifb.ev    = ev;
    ifa.abort = abort;
    ifb.abort = abort;
  endtask

  // Expected note index k cycles after the strobe.
  function automatic int exp_played(input int k, input int nc, input int gc);
    int off;
    if (k < 1 || k > 4 * (nc + gc)) return 0;
    off = k - 1;
    if ((off % (nc + gc)) < nc) return off / (nc + gc) + 1;
    return 0;
  endfunction

  task automatic expect_out(input string ctx, input int which, input int st,
                            input int pl, input int bz, input int dn);
    if (which == 0) begin
      check_vec({ctx, " a.note_state"},  32'(ifa.note_state),  32'(st));
      check_vec({ctx, " a.note_played"}, 32'(ifa.note_played), 32'(pl));
      check_vec({ctx, " a.busy"},        32'(ifa.busy),        32'(bz));
      check_vec({ctx, " a.done"},        32'(ifa.done),        32'(dn));
    end else begin
      check_vec({ctx, " b.note_state"},  32'(ifb.note_state),  32'(st));
      check_vec({ctx, " b.note_played"}, 32'(ifb.note_played), 32'(pl));
      check_vec({ctx, " b.busy"},        32'(ifb.busy),        32'(bz));
      check_vec({ctx, " b.done"},        32'(ifb.done),        32'(dn));
    end
  endtask

  // Expected outputs for a melody started k cycles ago.
  task automatic expect_mel(input string ctx, input int which, input int k,
                            input int id, input int nc, input int gc);
    int  tot;
    bit  in_mel;
    tot    = 4 * (nc + gc);
    in_mel = (k >= 1) && (k <= tot);
    expect_out($sformatf("%s k=%0d", ctx, k), which, in_mel ? id : 0,
               exp_played(k, nc, gc), in_mel ? 1 : 0, (k == tot) ? 1 : 0);
  endtask

  // Strobe ev in cycle 0, then check both instances through cycle 50.
  task automatic run_mel(input string ctx, input logic [5:0] ev, input int id);
    drive(ev, 1'b0);
    tick();
    drive(6'd0, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      expect_mel(ctx, 0, k, id, 10, 2);
      expect_mel(ctx, 1, k, id, 10, 0);
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(6'd0, 1'b0);
    #12;
    expect_out("reset", 0, 0, 0, 0, 0);
    expect_out("reset", 1, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // Single coin melody, and GAP_CYCLES=0 on the second instance.
    run_mel("s1", 6'b000001, 1);

    // Simultaneous strobes: highest index wins.
    run_mel("s2", 6'b100101, 6);

    // Request while busy at cycle 20.
    drive(6'b000001, 1'b0);
    tick();
    drive(6'd0, 1'b0);
    for (int k = 1; k <= 55; k++) begin
`ifdef PIEZO_QUEUE_EN
      if (k <= 48) expect_mel("s3", 0, k, 1, 10, 2);
      else expect_out($sformatf("s3q k=%0d", k), 0, 2, exp_played(k - 48, 10, 2), 1, 0);
`else
      expect_mel("s3", 0, k, 1, 10, 2);
`endif
      if (k == 20) drive(6'b000010, 1'b0);
      tick();
      drive(6'd0, 1'b0);
    end
    drive(6'd0, 1'b1);
    tick();
    drive(6'd0, 1'b0);
    expect_out("s3 cleanup", 0, 0, 0, 0, 0);
    expect_out("s3 cleanup", 1, 0, 0, 0, 0);
    tick();

    // Abort at cycle 15 with a request queued at cycle 10.
    drive(6'b000001, 1'b0);
    tick();
    drive(6'd0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      if (k <= 15) begin
        expect_mel("s4", 0, k, 1, 10, 2);
        expect_mel("s4", 1, k, 1, 10, 0);
      end else begin
        expect_out($sformatf("s4 k=%0d", k), 0, 0, 0, 0, 0);
        expect_out($sformatf("s4 k=%0d", k), 1, 0, 0, 0, 0);
      end
      if (k == 10) drive(6'b000010, 1'b0);
      if (k == 15) drive(6'd0, 1'b1);
      tick();
      drive(6'd0, 1'b0);
    end

    // abort together with ev in idle: stays idle.
    drive(6'b000100, 1'b1);
    tick();
    drive(6'd0, 1'b0);
    expect_out("abort+ev", 0, 0, 0, 0, 0);
    tick();
    expect_out("abort+ev next", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-melody at cycle 25, then a clean restart.
    drive(6'b000001, 1'b0);
    tick();
    drive(6'd0, 1'b0);
    for (int k = 1; k < 25; k++) tick();
    expect_mel("s6 pre", 0, 25, 1, 10, 2);
    #3;
    rst = 1'b1;
    #1;
    expect_out("s6 async rst", 0, 0, 0, 0, 0);
    expect_out("s6 async rst", 1, 0, 0, 0, 0);
    #10;
    rst = 1'b0;
    tick();
    expect_out("s6 released", 0, 0, 0, 0, 0);
    run_mel("s6", 6'b001000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
